alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
- Bit-serial ALU sequencer that sits directly upstream of alu_1bit and drives it.
- Accepts WIDTH-bit operands and an ALU opcode, then feeds alu_1bit one bit per cycle, LSB first, with a registered carry.
- Collects the result bits and publishes the WIDTH-bit result with flags.
- Gives a word-level ALU at one-bit datapath cost, for the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (min 2).
- CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- op  input  3  opcode, captured on accepted start: 000 AND, 010 OR, 100 ADD/SUB, 011 XOR.
- bnegate  input  1  invert B and set initial carry to 1 (SUB when op=100); captured on start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  last completed result; holds until the next done.
- cout  output  1  carry out of the MSB (ADD/SUB); 0 for logic ops.
- overflow  output  1  signed overflow (ADD/SUB): carry into MSB XOR carry out of MSB; 0 for logic ops.
- zero  output  1  result == 0.

Behaviour:
- Reset: async, all flops cleared.
  - state=IDLE; busy=0, done=0, result=0, cout=0, overflow=0, zero=0.
  - Shift registers, counter and carry flop all cleared.
- FSM states and transitions:
  - IDLE -> RUN on start=1.
  - RUN -> DONE when cnt==WIDTH-1.
  - DONE -> IDLE unconditionally after one cycle.
- Accept at edge k (IDLE, start=1):
  - Load a_sr=a, b_sr=b, op_r, bneg_r.
  - carry_r = bnegate when op=100, else 0; cnt=0.
- RUN, one bit per edge (edges k+1 .. k+WIDTH):
  - alu_1bit inputs: a_sr[0], b_sr[0], carry_r, bneg_r, op_r.
  - a_sr and b_sr shift right.
  - res_sr shifts right with the alu_1bit result entering at the MSB.
  - carry_r <= alu_1bit cout when op_r=100; otherwise carry_r stays 0.
  - cnt increments.
  - At cnt==WIDTH-1, capture c_msb_in = carry_r before the update.
- Edge k+WIDTH (completion):
  - result <= final res_sr (including the last bit); zero derived from it.
  - cout <= final carry; overflow <= c_msb_in XOR final carry, for op 100 only.
  - state=DONE.
- Timing:
  - done is high for exactly one cycle, in the cycle after edge k+WIDTH.
  - busy is high from edge k+1 through edge k+WIDTH.
  - Latency from accept to done = WIDTH cycles.
  - Back-to-back accept possible no earlier than the edge after DONE, i.e. throughput is one op per WIDTH+2 cycles.
- start in RUN or DONE is ignored; there is no queuing.
- Unsupported opcode (001, 101, 110, 111): runs full length, result=0, cout=0, overflow=0, zero=1.
- result, cout, overflow and zero hold their previous values throughout RUN and change only at the completion edge.
- Reset mid-RUN: immediate return to IDLE with all outputs 0. No done is generated and the in-flight operation is lost.
- Changes on a, b, op or bnegate after the accept edge have no effect.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode localparams OP_AND=3'b000, OP_OR=3'b010, OP_ADD=3'b100, OP_XOR=3'b011.
  - State encoding IDLE/RUN/DONE.
- The package is also used by alu_1bit and the control unit.
- Single sub-module: the existing alu_1bit, instantiated once as the bit slice.
- Shift registers, counter, carry flop and FSM live in alu_serial_seq.

Test Plan:
All scenarios run with WIDTH=8.
- ADD: a=8'h0F, b=8'h01, op=100, bnegate=0, start one cycle.
  - result=8'h10, cout=0, overflow=0, zero=0.
  - done exactly 8 cycles after the accept edge; busy high for 8 cycles.
- SUB: a=8'h05, b=8'h07, op=100, bnegate=1 -> result=8'hFE, cout=0, overflow=0, zero=0.
- SUB: a=8'h33, b=8'h33, bnegate=1 -> result=8'h00, cout=1, zero=1, overflow=0.
- Signed overflow: ADD a=8'h7F, b=8'h01 -> result=8'h80, overflow=1, cout=0.
- Logic ops, each with cout=0 and overflow=0:
  - AND F0&3C -> 8'h30.
  - OR 0F|F0 -> 8'hFF.
  - XOR AA^FF -> 8'h55.
- Robustness:
  - start held high through RUN: only one done per op, and result unchanged until done.
  - rst_n pulsed low after 4 bits: busy=0, done=0 and result=0 asynchronously; no done follows.
  - A new ADD 8'h02+8'h03 after reset completes with 8'h05.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes and sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return op == OP_ADD;
  endfunction

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice: AND/OR/XOR/ADD with optional B inversion; other opcodes yield 0.
module alu_1bit
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic       bnegate_i,
  input  logic [2:0] op_i,
  output logic       result_o,
  output logic       cout_o
);

  logic bb;

  always_comb begin
    bb       = b_i ^ bnegate_i;
    result_o = 1'b0;
    cout_o   = 1'b0;
    case (op_i)
      OP_AND: result_o = a_i & bb;
      OP_OR:  result_o = a_i | bb;
      OP_XOR: result_o = a_i ^ bb;
      OP_ADD: begin
        result_o = a_i ^ bb ^ cin_i;
        cout_o   = (a_i & bb) | (cin_i & (a_i ^ bb));
      end
      default: begin
        result_o = 1'b0;
        cout_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: feeds alu_1bit one operand bit per cycle, LSB first,
// and publishes the assembled word with carry, overflow and zero flags.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             bnegate,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  state_e             state_q;
  logic [WIDTH-1:0]   a_sr_q, b_sr_q;
  // Only WIDTH-1 bits are buffered; the last bit comes straight from the slice.
  logic [WIDTH-2:0]   res_sr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic               bneg_q;
  logic               carry_q;

  logic               slice_res, slice_cout;
  logic [WIDTH-1:0]   res_d;
  logic               last_bit;

  alu_1bit u_slice (
    .a_i       (a_sr_q[0]),
    .b_i       (b_sr_q[0]),
    .cin_i     (carry_q),
    .bnegate_i (bneg_q),
    .op_i      (op_q),
    .result_o  (slice_res),
    .cout_o    (slice_cout)
  );

  always_comb begin
    res_d    = {slice_res, res_sr_q};
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      bneg_q   <= 1'b0;
      carry_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            op_q    <= op;
            bneg_q  <= bnegate;
            carry_q <= is_arith(op) & bnegate;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= res_d[WIDTH-1:1];
          carry_q  <= is_arith(op_q) & slice_cout;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            // carry_q here is still the carry into the MSB.
            result   <= res_d;
            zero     <= (res_d == '0);
            cout     <= is_arith(op_q) & slice_cout;
            overflow <= is_arith(op_q) & (carry_q ^ slice_cout);
            busy     <= 1'b0;
            done     <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq at WIDTH=8 with a word-level reference model.
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   op = '0;
  logic         bnegate = 1'b0;
  logic         busy, done, cout, overflow, zero;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
    .bnegate(bnegate), .busy(busy), .done(done), .result(result),
    .cout(cout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word-level reference: {cout, overflow, result}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [2:0] o, input logic neg);
    logic [W-1:0] yy, r;
    logic [W:0]   s;
    logic         c, v;
    yy = neg ? ~y : y;
    c = 1'b0; v = 1'b0; r = '0;
    case (o)
      3'b000: r = x & yy;
      3'b010: r = x | yy;
      3'b011: r = x ^ yy;
      3'b100: begin
        s = {1'b0, x} + {1'b0, yy} + (W+1)'(neg);
        r = s[W-1:0];
        c = s[W];
        v = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
      end
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  // Model: countdown of WIDTH cycles from an accepted start, then a one-cycle done.
  logic         m_busy, m_done, m_cout, m_ovf, m_zero, m_in_done;
  logic [W-1:0] m_result;
  logic [W+1:0] m_pend;
  int           m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_cout <= 0; m_ovf <= 0; m_zero <= 0;
      m_result <= '0; m_left <= 0; m_in_done <= 0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      m_in_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_in_done <= 1'b1;
          m_result <= m_pend[W-1:0];
          m_ovf <= m_pend[W];
          m_cout <= m_pend[W+1];
          m_zero <= (m_pend[W-1:0] == '0);
        end
      end else if (!m_in_done && start) begin
        m_pend <= ref_op(a, b, op, bnegate);
        m_left <= W;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("model_busy", busy, m_busy);
    check("model_done", done, m_done);
    check("model_result", result, m_result);
    check("model_cout", cout, m_cout);
    check("model_ovf", overflow, m_ovf);
    check("model_zero", zero, m_zero);
  end

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2:0] o, input logic neg, input logic [W-1:0] er,
                        input logic ec, input logic ev, input logic ez);
    int lat, bcnt;
    @(negedge clk);
    a = x; b = y; op = o; bnegate = neg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~x; b = ~y; op = 3'b111; bnegate = ~neg;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    check({name, "_latency"}, lat, W);
    check({name, "_busy_cycles"}, bcnt, W);
    check({name, "_result"}, result, er);
    check({name, "_cout"}, cout, ec);
    check({name, "_ovf"}, overflow, ev);
    check({name, "_zero"}, zero, ez);
  endtask

  initial begin
    int dones, lat;
    logic [W-1:0] held;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {cout, overflow, zero}, 0);
    rst_n = 1'b1;

    run_op("add",    8'h0F, 8'h01, 3'b100, 1'b0, 8'h10, 0, 0, 0);
    run_op("sub",    8'h05, 8'h07, 3'b100, 1'b1, 8'hFE, 0, 0, 0);
    run_op("subeq",  8'h33, 8'h33, 3'b100, 1'b1, 8'h00, 1, 0, 1);
    run_op("ovf",    8'h7F, 8'h01, 3'b100, 1'b0, 8'h80, 0, 1, 0);
    run_op("and",    8'hF0, 8'h3C, 3'b000, 1'b0, 8'h30, 0, 0, 0);
    run_op("or",     8'h0F, 8'hF0, 3'b010, 1'b0, 8'hFF, 0, 0, 0);
    run_op("xor",    8'hAA, 8'hFF, 3'b011, 1'b0, 8'h55, 0, 0, 0);
    run_op("badop",  8'hAA, 8'h55, 3'b101, 1'b0, 8'h00, 0, 0, 1);

    // start held high from accept through the done cycle.
    @(negedge clk);
    held = result;
    a = 8'h21; b = 8'h12; op = 3'b100; bnegate = 1'b0; start = 1'b1;
    lat = 0; dones = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!done) check("held_result_stable", result, held);
    end
    if (done) dones++;
    check("held_result", result, 8'h33);
    start = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("held_done_count", dones, 1);

    // Reset partway through an operation.
    @(negedge clk);
    a = 8'h7F; b = 8'h7F; op = 3'b100; bnegate = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);

    run_op("post_rst_add", 8'h02, 8'h03, 3'b100, 1'b0, 8'h05, 0, 0, 0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
